// File: rtl/scaler_cfg_pkg.sv
// Shared types and constants for the scaler configuration controller.
package scaler_cfg_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StDivX,
    StDivY,
    StReady,
    StCommit
  } state_e;

  localparam logic [3:0]  PKT_CROP  = 4'd0;
  localparam logic [3:0]  PKT_SIZE  = 4'd1;
  localparam int unsigned FRAC_BITS = 16;
  localparam logic [31:0] RATIO_ONE = 32'h0001_0000;

  typedef struct packed {
    logic [3:0]  ptype;
    logic [15:0] sx;
    logic [15:0] sy;
    logic [15:0] ex;
    logic [15:0] ey;
    logic [15:0] zx;
    logic [15:0] zy;
    logic [7:0]  alg;
  } pkt_t;

  typedef struct packed {
    logic [15:0] start_x;
    logic [15:0] start_y;
    logic [15:0] crop_w;
    logic [15:0] crop_h;
    logic [15:0] size_x;
    logic [15:0] size_y;
    logic [7:0]  alg;
  } cfg_set_t;

endpackage

// File: rtl/scaler_cfg_ctrl_if.sv
// Parameter-packet input and active-configuration output bundle.
interface scaler_cfg_ctrl_if;
  logic        param_valid;
  logic [3:0]  packet_type;
  logic [15:0] start_x, start_y, end_x, end_y;
  logic [15:0] size_x, size_y;
  logic [7:0]  algorithm;
  logic        frame_start;

  logic [15:0] act_start_x, act_start_y;
  logic [15:0] act_crop_w, act_crop_h;
  logic [15:0] act_size_x, act_size_y;
  logic [31:0] act_ratio_x, act_ratio_y;
  logic [7:0]  act_algorithm;
  logic        cfg_update, busy, pending;
  logic [7:0]  err_cnt;

  modport master (
    output param_valid, packet_type, start_x, start_y, end_x, end_y, size_x, size_y,
           algorithm, frame_start,
    input  act_start_x, act_start_y, act_crop_w, act_crop_h, act_size_x, act_size_y,
           act_ratio_x, act_ratio_y, act_algorithm, cfg_update, busy, pending, err_cnt
  );

  modport slave (
    input  param_valid, packet_type, start_x, start_y, end_x, end_y, size_x, size_y,
           algorithm, frame_start,
    output act_start_x, act_start_y, act_crop_w, act_crop_h, act_size_x, act_size_y,
           act_ratio_x, act_ratio_y, act_algorithm, cfg_update, busy, pending, err_cnt
  );
endinterface

// File: rtl/seq_div_u32_u16.sv
// Iterative restoring divider: one quotient bit per cycle, 32 cycles after start.
module seq_div_u32_u16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic        done,
  output logic [31:0] quotient
);

  logic [15:0] rem_q, rem_nx;
  logic [31:0] quo_q, quo_nx;
  logic [15:0] dvs_q;
  logic [4:0]  cnt_q;
  logic        run_q;
  logic [16:0] rem_sh;
  logic        ge;

  // Remainder stays below the divisor, so 16 bits hold it between steps.
  always_comb begin
    rem_sh   = {rem_q, quo_q[31]};
    ge       = {16'd0, rem_sh} >= {17'd0, dvs_q};
    rem_nx   = ge ? 16'(rem_sh - {1'b0, dvs_q}) : rem_sh[15:0];
    quo_nx   = {quo_q[30:0], ge};
    done     = run_q && (cnt_q == 5'd31);
    quotient = quo_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (abort) begin
      run_q <= 1'b0;
    end else if (start) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      rem_q <= rem_nx;
      quo_q <= quo_nx;
      cnt_q <= cnt_q + 5'd1;
      run_q <= (cnt_q != 5'd31);
    end
  end

endmodule

// File: rtl/scaler_cfg_ctrl.sv
// Captures and validates scaler parameter packets, computes 16.16 ratios and
// commits the full set to the scaler only at a frame boundary.
module scaler_cfg_ctrl #(
  parameter int unsigned MAX_W = 1920,
  parameter int unsigned MAX_H = 1080
) (
  input logic              clk,
  input logic              rst_n,
  scaler_cfg_ctrl_if.slave cfg
);
  import scaler_cfg_pkg::*;

  localparam logic [15:0] MaxW = 16'(MAX_W);
  localparam logic [15:0] MaxH = 16'(MAX_H);
  localparam cfg_set_t CfgRst = '{start_x: 16'd0, start_y: 16'd0, crop_w: MaxW, crop_h: MaxH,
                                  size_x: MaxW, size_y: MaxH, alg: 8'd0};

  state_e      state_q, state_d;
  pkt_t        cap_q;
  logic        cap_new_q, cap_new_d;
  cfg_set_t    stg_q, stg_d, act_q, act_d;
  logic [31:0] ratio_x_q, ratio_x_d, ratio_y_q, ratio_y_d;
  logic [31:0] act_rx_q, act_rx_d, act_ry_q, act_ry_d;
  logic        intr_q, intr_d, upd_q, upd_d;
  logic [7:0]  err_q, err_d;
  logic        pkt_ok;
  logic        div_start, div_abort, div_done;
  logic [31:0] div_dividend, div_quotient;
  logic [15:0] div_divisor;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q <= '0;
    end else if (cfg.param_valid) begin
      cap_q <= '{ptype: cfg.packet_type, sx: cfg.start_x, sy: cfg.start_y, ex: cfg.end_x,
                 ey: cfg.end_y, zx: cfg.size_x, zy: cfg.size_y, alg: cfg.algorithm};
    end
  end

  always_comb begin
    pkt_ok = 1'b0;
    if (cap_q.ptype == PKT_CROP) begin
      pkt_ok = (cap_q.ex > cap_q.sx) && (cap_q.ey > cap_q.sy) &&
               (cap_q.ex <= MaxW) && (cap_q.ey <= MaxH);
    end else if (cap_q.ptype == PKT_SIZE) begin
      pkt_ok = (cap_q.zx != 16'd0) && (cap_q.zx <= MaxW) &&
               (cap_q.zy != 16'd0) && (cap_q.zy <= MaxH);
    end
  end

  always_comb begin
    state_d   = state_q;
    cap_new_d = cap_new_q;
    stg_d     = stg_q;
    act_d     = act_q;
    ratio_x_d = ratio_x_q;
    ratio_y_d = ratio_y_q;
    act_rx_d  = act_rx_q;
    act_ry_d  = act_ry_q;
    intr_d    = intr_q;
    err_d     = err_q;
    upd_d     = 1'b0;
    div_start = 1'b0;
    div_abort = 1'b0;
    unique case (state_q)
      StIdle: if (cap_new_q) state_d = StCheck;
      StCheck: begin
        cap_new_d = 1'b0;
        intr_d    = 1'b0;
        if (pkt_ok) begin
          if (cap_q.ptype == PKT_CROP) begin
            stg_d.start_x = cap_q.sx;
            stg_d.start_y = cap_q.sy;
            stg_d.crop_w  = cap_q.ex - cap_q.sx;
            stg_d.crop_h  = cap_q.ey - cap_q.sy;
          end else begin
            stg_d.size_x = cap_q.zx;
            stg_d.size_y = cap_q.zy;
          end
          stg_d.alg = cap_q.alg;
          div_start = 1'b1;
          state_d   = StDivX;
        end else begin
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
          // A rejected packet must not lose a set that was already on its way to commit.
          div_start = intr_q;
          state_d   = intr_q ? StDivX : StIdle;
        end
      end
      StDivX: begin
        if (cap_new_q) begin
          div_abort = 1'b1;
          intr_d    = 1'b1;
          state_d   = StCheck;
        end else if (div_done) begin
          ratio_x_d = div_quotient;
          div_start = 1'b1;
          state_d   = StDivY;
        end
      end
      StDivY: begin
        if (cap_new_q) begin
          div_abort = 1'b1;
          intr_d    = 1'b1;
          state_d   = StCheck;
        end else if (div_done) begin
          ratio_y_d = div_quotient;
          state_d   = StReady;
        end
      end
      StReady: begin
        if (cap_new_q) begin
          intr_d  = 1'b1;
          state_d = StCheck;
        end else if (cfg.frame_start) begin
          state_d = StCommit;
        end
      end
      StCommit: begin
        act_d    = stg_q;
        act_rx_d = ratio_x_q;
        act_ry_d = ratio_y_q;
        upd_d    = 1'b1;
        state_d  = cap_new_q ? StCheck : StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (cfg.param_valid) cap_new_d = 1'b1;

    // X division starts from the staging set being written in CHECK.
    if (state_q == StDivX) begin
      div_dividend = {stg_q.crop_h, {FRAC_BITS{1'b0}}};
      div_divisor  = stg_q.size_y;
    end else begin
      div_dividend = {stg_d.crop_w, {FRAC_BITS{1'b0}}};
      div_divisor  = stg_d.size_x;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cap_new_q <= 1'b0;
      stg_q     <= CfgRst;
      act_q     <= CfgRst;
      ratio_x_q <= RATIO_ONE;
      ratio_y_q <= RATIO_ONE;
      act_rx_q  <= RATIO_ONE;
      act_ry_q  <= RATIO_ONE;
      intr_q    <= 1'b0;
      err_q     <= 8'd0;
      upd_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cap_new_q <= cap_new_d;
      stg_q     <= stg_d;
      act_q     <= act_d;
      ratio_x_q <= ratio_x_d;
      ratio_y_q <= ratio_y_d;
      act_rx_q  <= act_rx_d;
      act_ry_q  <= act_ry_d;
      intr_q    <= intr_d;
      err_q     <= err_d;
      upd_q     <= upd_d;
    end
  end

  seq_div_u32_u16 u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .abort    (div_abort),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .done     (div_done),
    .quotient (div_quotient)
  );

  assign cfg.act_start_x   = act_q.start_x;
  assign cfg.act_start_y   = act_q.start_y;
  assign cfg.act_crop_w    = act_q.crop_w;
  assign cfg.act_crop_h    = act_q.crop_h;
  assign cfg.act_size_x    = act_q.size_x;
  assign cfg.act_size_y    = act_q.size_y;
  assign cfg.act_algorithm = act_q.alg;
  assign cfg.act_ratio_x   = act_rx_q;
  assign cfg.act_ratio_y   = act_ry_q;
  assign cfg.cfg_update    = upd_q;
  assign cfg.err_cnt       = err_q;
  assign cfg.busy          = (state_q == StCheck) || (state_q == StDivX) || (state_q == StDivY);
  assign cfg.pending       = (state_q == StReady);

endmodule

// File: doc/scaler_cfg_ctrl.md
# scaler_cfg_ctrl

Configuration controller between the UART packet parser and the video scaler core. It captures crop-window and output-size parameter packets and validates them. A sequential divider then computes the 16.16 fixed-point scale ratios, and the complete parameter set is committed to the scaler only on a frame boundary, so a frame is never processed with mixed settings.

## Interface
- MAX_W, 1920: maximum input/output width in pixels
- MAX_H, 1080: maximum input/output height in lines
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- param_valid  in  1  one-cycle pulse: the parameter fields below are valid
- packet_type  in  4  0 = crop window, 1 = output size, other = illegal
- start_x, start_y, end_x, end_y  in  16 each  crop window corners, end exclusive
- size_x, size_y  in  16 each  output size
- algorithm  in  8  interpolation select, forwarded unchecked
- frame_start  in  1  one-cycle pulse at the start of vertical blanking
- act_start_x, act_start_y  out  16  active crop origin; reset 0
- act_crop_w, act_crop_h  out  16  active crop size; reset MAX_W, MAX_H
- act_size_x, act_size_y  out  16  active output size; reset MAX_W, MAX_H
- act_ratio_x, act_ratio_y  out  32  crop/size in 16.16 format; reset 32'h0001_0000
- act_algorithm  out  8  reset 0
- cfg_update  out  1  one-cycle pulse when act_* change; reset 0
- busy  out  1  validation/division in progress; reset 0
- pending  out  1  computed set waiting for frame_start; reset 0
- err_cnt  out  8  count of rejected packets, saturates at 255; reset 0

## Operation
- Capture register: every param_valid latches all inputs and sets cap_new on the next edge. A later pulse overwrites an unconsumed capture (latest wins).
- Staging set (crop origin, crop size, output size, algorithm) is reset to the act_* reset values.
- FSM states: IDLE, CHECK, DIV_X, DIV_Y, READY, COMMIT.
- IDLE: if cap_new, go to CHECK.
- CHECK (1 cycle) consumes cap_new and validates the capture:
  - type 0 requires end_x > start_x, end_y > start_y, end_x ≤ MAX_W, end_y ≤ MAX_H.
  - type 1 requires 1 ≤ size_x ≤ MAX_W and 1 ≤ size_y ≤ MAX_H.
  - Any other type is invalid.
- Valid packet, type 0: staging origin = start; crop_w = end_x − start_x; crop_h = end_y − start_y.
- Valid packet, type 1: staging output size = size.
- Valid packet, either type: staging algorithm updated; go to DIV_X.
- Invalid packet: staging unchanged, err_cnt increments (saturating), FSM returns to IDLE. If a commit-pending set was interrupted, FSM returns to DIV_X and recomputes from staging.
- DIV_X: ratio_x = ({crop_w,16'h0}) / size_x, unsigned restoring division, 32 cycles, quotient truncated. DIV_Y does the same for ratio_y. Then go to READY.
- cap_new in DIV_X, DIV_Y or READY aborts the division or discards the ready result and goes to CHECK.
- READY: on frame_start, go to COMMIT.
- COMMIT: act_* = staging and ratios, cfg_update = 1; go to IDLE, or to CHECK if cap_new.
- frame_start in any state other than READY is ignored.
- busy = state ∈ {CHECK, DIV_X, DIV_Y}; pending = state == READY.
- rst_n low at any time: all registers, staging, capture and FSM return to reset values immediately. A division in progress is lost.

## Timing
- param_valid sampled at cycle 0; CHECK at cycle 2; DIV_X cycles 3–34; DIV_Y cycles 35–66; READY from cycle 67.
- frame_start sampled in READY at cycle N: COMMIT in cycle N+1, act_* updated and cfg_update high in cycle N+2.
- param_valid and frame_start in the same READY cycle: the older set commits; the new set runs through CHECK afterwards and commits at a later frame_start.
- Divider: 32-bit dividend, 16-bit divisor, 32-bit quotient, 33-bit remainder compare. The divisor is never 0 after validation.

## Structure
- Shared package scaler_cfg_pkg holds:
  - FSM state encoding.
  - PKT_CROP = 4'd0 and PKT_SIZE = 4'd1.
  - FRAC_BITS = 16 and RATIO_ONE = 32'h0001_0000.
- Sub-module seq_div_u32_u16 implements the iterative restoring divider with start/done/abort. It is instantiated once and shared by DIV_X and DIV_Y.

## Test plan
- Type 1 packet with size 960×540 (default crop), frame_start at cycle 100 → cycle 102: cfg_update = 1, ratio_x = ratio_y = 32'h0002_0000.
- Type 0 packet 0,0,1920,1080, then type 1 packet 1280×720 → committed ratios 32'h0001_8000 and 32'h0001_8000; crop 1920×1080.
- Type 0 packet with end_x = 100, start_x = 100 → err_cnt = 1; act_* and cfg_update unchanged, including at the next frame_start.
- Second type 1 packet (640×360) issued during DIV_Y of a first one (960×540) → only 640×360 commits, ratio_x = 32'h0003_0000, exactly one cfg_update.
- frame_start pulses during busy are ignored; commit occurs on the first frame_start after READY; pending drops with cfg_update.
- rst_n low during DIV_X → all outputs return to reset values; busy = 0, pending = 0, err_cnt = 0.
